// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA timing generator with sync/blank realignment to the pixel pipeline
module vga_sync_gen #(
  parameter int H_DISP   = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_DISP   = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIPE_DLY = 2,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [2:0] rgb_in,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [2:0] rgb_out,
  output logic       frame_tick
);

  localparam int H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_DISP + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_DISP);
  localparam logic [9:0] V_VIS_END  = 10'(V_DISP);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_DISP + H_FP);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_DISP + V_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_DISP + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_END = 10'(V_DISP + V_FP + V_SYNC);

  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;
  logic       r_frame_tick;
  logic [2:0] r_rgb_out;
  // Each delay stage packs {vs, hs, vis}; stage 0 holds the raw signals one cycle old.
  logic [2:0] r_dly [0:PIPE_DLY];

  logic       w_h_last;
  logic       w_v_last;
  logic [2:0] w_raw;
  logic [2:0] w_last;
  logic       w_pre_vis;

  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);

  assign w_raw[0] = (r_h_cnt < H_VIS_END) && (r_v_cnt < V_VIS_END);
  assign w_raw[1] = (r_h_cnt >= H_SYNC_BEG) && (r_h_cnt < H_SYNC_END);
  assign w_raw[2] = (r_v_cnt >= V_SYNC_BEG) && (r_v_cnt < V_SYNC_END);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_h_cnt      <= '0;
      r_v_cnt      <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_h_last && w_v_last;
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? 10'd0 : r_v_cnt + 10'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 10'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i <= PIPE_DLY; i++) r_dly[i] <= '0;
    end else begin
      r_dly[0] <= w_raw;
      for (int i = 1; i <= PIPE_DLY; i++) r_dly[i] <= r_dly[i-1];
    end
  end

  // The colour arriving now belongs to the pixel one stage before the output stage.
  generate
    if (PIPE_DLY == 0) begin : g_pre_live
      assign w_pre_vis = w_raw[0];
    end else begin : g_pre_dly
      assign w_pre_vis = r_dly[PIPE_DLY-1][0];
    end
  endgenerate

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_rgb_out <= '0;
    end else begin
      r_rgb_out <= w_pre_vis ? rgb_in : 3'b000;
    end
  end

  assign w_last     = r_dly[PIPE_DLY];
  assign pix_x      = r_h_cnt;
  assign pix_y      = r_v_cnt;
  assign video_on   = w_last[0];
  assign hsync      = SYNC_POL ? w_last[1] : ~w_last[1];
  assign vsync      = SYNC_POL ? w_last[2] : ~w_last[2];
  assign rgb_out    = r_rgb_out;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - self-checking bench for vga_sync_gen on a reduced display geometry
module tb_vga_sync_gen;

  localparam int HD = 40, HF = 4, HS = 8, HB = 6;
  localparam int VD = 30, VF = 3, VS = 2, VB = 4;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FT = HT * VT;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] rgb_in = 3'b000;

  logic [9:0] a_x, a_y, b_x, b_y;
  logic       a_hs, a_vs, a_vo, a_ft, b_hs, b_vs, b_vo, b_ft;
  logic [2:0] a_rgb, b_rgb;

  int checks = 0;
  int failures = 0;
  int n = 0;
  int mode = 0;
  int vid_cnt = 0, vs_cnt = 0, mk = 0, mk_n = -1;
  bit done = 1'b0;
  logic [2:0] hist [0:16383];

  always #5 clk = ~clk;

  vga_sync_gen #(.H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                 .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                 .PIPE_DLY(2), .SYNC_POL(1'b0)) dut (
    .CLK(clk), .RESET(rst), .rgb_in(rgb_in), .pix_x(a_x), .pix_y(a_y),
    .hsync(a_hs), .vsync(a_vs), .video_on(a_vo), .rgb_out(a_rgb), .frame_tick(a_ft));

  vga_sync_gen #(.H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                 .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                 .PIPE_DLY(0), .SYNC_POL(1'b1)) dut_pol (
    .CLK(clk), .RESET(rst), .rgb_in(rgb_in), .pix_x(b_x), .pix_y(b_y),
    .hsync(b_hs), .vsync(b_vs), .video_on(b_vo), .rgb_out(b_rgb), .frame_tick(b_ft));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s n=%0d actual=%0d expected=%0d", nm, n, act, exp);
    end
  endtask

  // Expected outputs in cycle k after reset release, from the frame geometry alone.
  task automatic model(input int k, input int pd, input bit pol,
                       output int ex, output int ey, output int ehs, output int evs,
                       output int evo, output int ergb, output int eft);
    int m, h, v, hs_a, vs_a;
    ex  = k % HT;
    ey  = (k / HT) % VT;
    eft = (k > 0 && k % FT == 0) ? 1 : 0;
    m = k - pd - 1;
    evo = 0; hs_a = 0; vs_a = 0; ergb = 0;
    if (m >= 0) begin
      h = m % HT;
      v = (m / HT) % VT;
      evo  = (h < HD && v < VD) ? 1 : 0;
      hs_a = (h >= HD + HF && h < HD + HF + HS) ? 1 : 0;
      vs_a = (v >= VD + VF && v < VD + VF + VS) ? 1 : 0;
      if (evo == 1) ergb = int'(hist[m + pd]);
    end
    ehs = pol ? hs_a : 1 - hs_a;
    evs = pol ? vs_a : 1 - vs_a;
  endtask

  always @(negedge clk) begin
    int ex, ey, ehs, evs, evo, ergb, eft;
    if (!rst && !done) begin
      model(n, 2, 1'b0, ex, ey, ehs, evs, evo, ergb, eft);
      chk("a_pix_x", 32'(a_x), ex);
      chk("a_pix_y", 32'(a_y), ey);
      chk("a_hsync", 32'(a_hs), ehs);
      chk("a_vsync", 32'(a_vs), evs);
      chk("a_video_on", 32'(a_vo), evo);
      chk("a_rgb_out", 32'(a_rgb), ergb);
      chk("a_frame_tick", 32'(a_ft), eft);
      model(n, 0, 1'b1, ex, ey, ehs, evs, evo, ergb, eft);
      chk("b_pix_x", 32'(b_x), ex);
      chk("b_pix_y", 32'(b_y), ey);
      chk("b_hsync", 32'(b_hs), ehs);
      chk("b_vsync", 32'(b_vs), evs);
      chk("b_video_on", 32'(b_vo), evo);
      chk("b_rgb_out", 32'(b_rgb), ergb);
      chk("b_frame_tick", 32'(b_ft), eft);

      if (n == 46)   chk("pin_a_hs_before", 32'(a_hs), 1);
      if (n == 47)   chk("pin_a_hs_fall", 32'(a_hs), 0);
      if (n == 54)   chk("pin_a_hs_last", 32'(a_hs), 0);
      if (n == 55)   chk("pin_a_hs_rise", 32'(a_hs), 1);
      if (n == 44)   chk("pin_b_hs_idle", 32'(b_hs), 0);
      if (n == 45)   chk("pin_b_hs_act", 32'(b_hs), 1);
      if (n == 1916) chk("pin_a_vs_before", 32'(a_vs), 1);
      if (n == 1917) chk("pin_a_vs_fall", 32'(a_vs), 0);
      if (n == 2032) chk("pin_a_vs_last", 32'(a_vs), 0);
      if (n == 2033) chk("pin_a_vs_rise", 32'(a_vs), 1);
      if (n == 2262) chk("pin_a_tick", 32'(a_ft), 1);
      if (n == 2261) chk("pin_a_tick_early", 32'(a_ft), 0);

      if (n > 0 && n % FT == 0) begin
        chk("frame_video_cycles", vid_cnt, 1200);
        chk("frame_vsync_cycles", vs_cnt, 116);
        vid_cnt = 0;
        vs_cnt  = 0;
      end
      vid_cnt += int'(a_vo);
      vs_cnt  += int'(!a_vs);

      if (mode == 2 && a_rgb != 3'b000) begin
        mk++;
        mk_n = n;
        chk("marker_value", 32'(a_rgb), 32'(3'b010));
        chk("marker_video_on", 32'(a_vo), 1);
      end
    end
  end

  function automatic logic [2:0] pick(input int k);
    int h, v;
    h = k % HT;
    v = (k / HT) % VT;
    case (mode)
      1:       return 3'b111;
      2:       return (h == 2 && v == 5) ? 3'b010 : 3'b000;
      default: return 3'($urandom_range(0, 7));
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    n++;
    rgb_in = pick(n);
    hist[n] = rgb_in;
  endtask

  task automatic check_reset();
    chk("rst_a_pix_x", 32'(a_x), 0);
    chk("rst_a_pix_y", 32'(a_y), 0);
    chk("rst_a_hsync", 32'(a_hs), 1);
    chk("rst_a_vsync", 32'(a_vs), 1);
    chk("rst_a_video_on", 32'(a_vo), 0);
    chk("rst_a_rgb_out", 32'(a_rgb), 0);
    chk("rst_a_frame_tick", 32'(a_ft), 0);
    chk("rst_b_hsync", 32'(b_hs), 0);
    chk("rst_b_vsync", 32'(b_vs), 0);
    chk("rst_b_video_on", 32'(b_vo), 0);
    chk("rst_b_rgb_out", 32'(b_rgb), 0);
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1;
    n = 0;
    vid_cnt = 0;
    vs_cnt = 0;
    rgb_in = pick(0);
    hist[0] = rgb_in;
    rst = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 check_reset();
    release_reset();

    while (n < FT) step();
    mode = 1;
    while (n < 2 * FT) step();
    mode = 2;
    while (n < 3 * FT) step();
    chk("marker_count", mk, 1);
    chk("marker_cycle", mk_n, 2 * FT + 5 * HT + 3);
    mode = 0;

    while (n < 3 * FT + 20 * HT + 30) step();
    chk("pre_reset_pix_x", 32'(a_x), 30);
    chk("pre_reset_pix_y", 32'(a_y), 20);
    #2 rst = 1'b1;
    #1 check_reset();
    release_reset();
    while (n < FT + 20) step();

    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Timing generator for the 640x480 @ 60 Hz VGA display path, running on the 25 MHz pixel clock. Drives the pixel scan coordinates (`pix_x`, `pix_y`) consumed by the character/text generator. Receives that generator's colour back and realigns the sync and blanking signals to the generator's pipeline latency before driving the VGA connector. Also emits a once-per-frame tick for blink timers and frame-synchronous register updates.

## Interface

Parameters:
- `H_DISP`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch (pixels)
- `H_SYNC`, 96: horizontal sync width (pixels)
- `H_BP`, 48: horizontal back porch (pixels)
- `V_DISP`, 480: visible lines
- `V_FP`, 10: vertical front porch (lines)
- `V_SYNC`, 2: vertical sync width (lines)
- `V_BP`, 33: vertical back porch (lines)
- `PIPE_DLY`, 2: cycles from `pix_x`/`pix_y` to valid `rgb_in`. Legal range 0..7.
- `SYNC_POL`, 0: sync active level (0 = active-low, 1 = active-high)

Ports:
- `CLK`, input, 1: 25 MHz pixel clock. One pixel per cycle.
- `RESET`, input, 1: asynchronous, active-high reset
- `rgb_in`, input, 3: colour from the text generator, valid `PIPE_DLY` cycles after the matching coordinates
- `pix_x`, output, 10: horizontal counter, 0..H_TOT-1
- `pix_y`, output, 10: vertical counter, 0..V_TOT-1
- `hsync`, output, 1: horizontal sync to connector, aligned with `rgb_out`
- `vsync`, output, 1: vertical sync to connector, aligned with `rgb_out`
- `video_on`, output, 1: visible-area flag, aligned with `rgb_out`
- `rgb_out`, output, 3: blanked colour to connector
- `frame_tick`, output, 1: one-cycle pulse at the start of each frame

## Operation

- Totals are `H_TOT = H_DISP+H_FP+H_SYNC+H_BP` (800) and `V_TOT` (525). Both must be ≤1024.
- Horizontal counter `h_cnt`:
  - Increments every cycle.
  - At H_TOT-1 it wraps to 0, and `v_cnt` increments.
  - `v_cnt` wraps to 0 when it is at V_TOT-1 and `h_cnt` is at H_TOT-1 simultaneously.
- `pix_x = h_cnt` and `pix_y = v_cnt`. Both are the counter registers directly, with no added latency.
- Raw signals are combinational from the counters:
  - `vis_raw = (h_cnt < H_DISP) && (v_cnt < V_DISP)`
  - `hs_raw = (h_cnt >= H_DISP+H_FP) && (h_cnt < H_DISP+H_FP+H_SYNC)`
  - `vs_raw`: the same form on `v_cnt`
- Alignment delay line:
  - `vis_raw`, `hs_raw` and `vs_raw` pass through a shift register of depth `PIPE_DLY+1`.
  - Its last stage drives `video_on`, and `hsync`/`vsync` after polarity mapping.
  - Polarity mapping: output = `hs_raw` when `SYNC_POL=1`, else `~hs_raw`.
- Colour output:
  - `rgb_out` is registered: each edge loads `rgb_in` if the delay-line stage `PIPE_DLY` (one before last) is visible, else `3'b000`.
  - Therefore `rgb_out` and `video_on` always refer to the same pixel.
  - `rgb_out` is never non-zero while `video_on=0`.
- `frame_tick` is registered. It is set to 1 on the edge where both counters wrap to 0, and is 0 on every other edge.

## Timing

- Reset (asynchronous, immediate, also mid-frame):
  - `h_cnt`, `v_cnt` = 0
  - All delay stages = not visible, sync inactive
  - `video_on` = 0, `rgb_out` = 0, `frame_tick` = 0
  - `hsync`/`vsync` = inactive level: 1 when `SYNC_POL=0`
- First edge after reset release: `pix_x` = 1. Counters run freely thereafter; there are no stall or enable inputs.
- Latency from coordinates to connector is `PIPE_DLY+1` cycles. With the default of 2, the output seen in cycle t describes the counters of cycle t-3.
- `frame_tick` is not asserted directly out of reset, because reset itself is not a wrap. The first pulse comes H_TOT*V_TOT = 420000 cycles after release, in the cycle where `pix_x=0`, `pix_y=0`.
- Line period is 800 cycles. Frame period is 420000 cycles.
- `PIPE_DLY=0` is legal: the delay line is 1 stage, and `rgb_out` samples `rgb_in` against the live `vis_raw`.

## Test plan

- Reset release, defaults:
  - Counters step 0,1,2,…; `pix_x` wraps 799→0 with `pix_y` +1.
  - `hsync`=1, `vsync`=1, `rgb_out`=0 for the first 3 cycles.
- Horizontal sync:
  - `hsync` goes low in the cycle `pix_x`=659.
  - It returns high at `pix_x`=755, a width of 96 cycles, on every line.
- Vertical sync and frame:
  - `vsync` is low from (`pix_y`=490, `pix_x`=3) through (`pix_y`=492, `pix_x`=2), i.e. 1600 cycles.
  - `frame_tick` pulses exactly once per 420000 cycles, coincident with `pix_x`=0, `pix_y`=0.
- Blanking and alignment:
  - Drive `rgb_in`=3'b111 constantly.
  - `rgb_out`=3'b111 exactly while `video_on`=1: 640 cycles per line, starting 3 cycles after `pix_x`=0.
  - `rgb_out`=0 elsewhere and on lines 480..524.
- Alignment marker:
  - Drive `rgb_in`=3'b010 only in the cycle when `pix_x`=PIPE_DLY (2) on line 5, and 0 otherwise.
  - `rgb_out`=3'b010 for exactly one cycle, the same cycle in which `video_on` first rises on that line.
- Mid-frame reset: assert `RESET` at `pix_x`=300, `pix_y`=200.
  - In the same cycle, outputs go to reset values without waiting for a clock edge.
  - After release, no `frame_tick` until 420000 cycles later.
  - Repeat with `SYNC_POL`=1: sync outputs idle low.
